mix_columns_pipe: RTL and testbench
===================================

MIX_COLUMNS_PIPE -- requirements
Module: mix_columns_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, as the width of each byte lane port; only bits [7:0] carry data.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port run, input, 1, start pulse that accepts a new 16-byte state.
REQ-005 SHALL have ports in0..in15, input, DATA_W each, the state in row-major order: in[4*r+c] is row r, column c.
REQ-006 SHALL have ports out0..out15, output, DATA_W each, the result in the same row-major order.
REQ-007 SHALL have port done, output, 1, a one-cycle pulse marking that out0..out15 hold a new result.
REQ-008 SHALL have port busy, output, 1, high while an operation is in flight.

Function
REQ-009 SHALL implement AES MixColumns on each column {in c, in 4+c, in 8+c, in 12+c}:
- b0 = 2a0^3a1^a2^a3, with the other rows as the cyclic rotation.
- GF(2^8) multiplication uses reduction polynomial 0x11B (xtime: shift left, XOR 0x1B if bit 7 was set).
REQ-010 SHALL use FSM states IDLE, BUSY and DONE, with a 2-bit column counter col.
REQ-011 SHALL, in IDLE with run=1 at cycle T:
- latch in0..in15[7:0] into a working register;
- enter BUSY with col=0.
REQ-012 SHALL, in BUSY, transform column col in the working register each cycle (T+1..T+4) and increment col; at col=3 it SHALL enter DONE.
REQ-013 SHALL, in DONE (cycle T+5), copy all 16 bytes to the output registers atomically and assert done=1 for exactly that cycle.
REQ-014 SHALL give a fixed latency of 5 cycles from run to done.
REQ-015 SHALL drive busy=1 in BUSY and DONE, and 0 in IDLE.
REQ-016 SHALL keep outputs stable from T+5 until the next DONE; intermediate column results SHALL never appear on the outputs.
REQ-017 SHALL zero-extend each output byte: out[DATA_W-1:8]=0; input bits [DATA_W-1:8] SHALL be ignored.
REQ-018 SHALL ignore run while in BUSY.
REQ-019 SHALL, when run=1 in DONE, latch the new inputs and go directly to BUSY (back-to-back throughput of one block per 5 cycles); otherwise DONE SHALL return to IDLE.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, set state=IDLE, col=0, done=0, busy=0, all out0..out15=0 and the working register to 0.
REQ-021 SHALL give rst priority over run; rst in mid-operation SHALL abort with no done pulse, and the aborted block SHALL never appear on the outputs.

Configuration
REQ-022 SHALL, with macro MIX_COLUMNS_INV_EN defined:
- add input port inv (1 bit), sampled with run and held for the whole operation;
- inv=1 SHALL select InvMixColumns (coefficients 0e,0b,0d,09);
- inv=0 SHALL select forward MixColumns.
REQ-023 SHALL, without MIX_COLUMNS_INV_EN, have no inv port and implement forward MixColumns only, with no inverse logic synthesized.

Structure
REQ-024 SHALL place the FSM state encodings, the constant 0x1B and the forward/inverse coefficient constants in the shared AES package/header used by the other AES units.
REQ-025 SHALL instantiate exactly one combinational sub-module, mix_column_single: 4 bytes in, 4 bytes out, plus an inv select when MIX_COLUMNS_INV_EN is defined; it SHALL be reused across the 4 columns.

Verification
REQ-026 Scenario: column 0 = db,13,53,45, run pulse -> done at T+5, column 0 outputs = 8e,4d,a1,bc.
REQ-027 Scenario: columns = f2,0a,22,5c / 01,01,01,01 / c6,c6,c6,c6 / d4,d4,d4,d5 -> 9f,dc,58,9d / 01,01,01,01 / c6,c6,c6,c6 / d5,d5,d7,d6, with upper bits of out = 0.
REQ-028 Scenario: run held high continuously with inputs changing every cycle -> done every 5 cycles, each result matching the inputs sampled at its accepting edge; run during BUSY has no effect.
REQ-029 Scenario: rst at T+3 of an operation -> no done pulse, outputs = 0, busy = 0; a following run completes normally.
REQ-030 Scenario (MIX_COLUMNS_INV_EN): inv=1, column 8e,4d,a1,bc -> db,13,53,45; forward followed by inverse on random states returns the original state.

Source files
------------

// File: rtl/mix_columns_pipe_pkg.sv
// Shared AES package: FSM encodings, GF(2^8) reduction constant, MixColumns coefficients
// and the GF(2^8) multiply helper used by the AES datapath units.
package mix_columns_pipe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] XTIME_POLY = 8'h1B;

   // Row-0 coefficients; coef[k] multiplies the byte k rows below the output row.
   localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
   localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0D, 8'h0B, 8'h0E};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
   endfunction

   // Constant k folds this to a fixed XOR network of xtime taps.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (k[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/mix_columns_pipe_mix_column_single.sv
// Combinational MixColumns of one 4-byte column (row 0 in col_in[0]).
// With MIX_COLUMNS_INV_EN defined, inv=1 selects InvMixColumns.
module mix_column_single
   import mix_columns_pipe_pkg::*;
(
`ifdef MIX_COLUMNS_INV_EN
   input  logic            inv,
`endif
   input  logic [3:0][7:0] col_in,
   output logic [3:0][7:0] col_out
);

   function automatic logic [3:0][7:0] mix(input logic [3:0][7:0] a,
                                           input logic [3:0][7:0] coef);
      logic [3:0][7:0] b;
      for (int unsigned r = 0; r < 4; r++) begin
         b[r] = '0;
         for (int unsigned j = 0; j < 4; j++) begin
            b[r] = b[r] ^ gf_mul(a[j], coef[2'(j + 4 - r)]);
         end
      end
      return b;
   endfunction

   always_comb begin
`ifdef MIX_COLUMNS_INV_EN
      col_out = inv ? mix(col_in, INV_COEF) : mix(col_in, FWD_COEF);
`else
      col_out = mix(col_in, FWD_COEF);
`endif
   end

endmodule

// File: rtl/mix_columns_pipe.sv
// Iterative AES MixColumns: one column per cycle through a shared mixer, 5-cycle run-to-done.
// Define MIX_COLUMNS_INV_EN to add the inv port and InvMixColumns support.
module mix_columns_pipe
   import mix_columns_pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
`ifdef MIX_COLUMNS_INV_EN
   input  logic              inv,
`endif
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   input  logic [DATA_W-1:0] in9,
   input  logic [DATA_W-1:0] in10,
   input  logic [DATA_W-1:0] in11,
   input  logic [DATA_W-1:0] in12,
   input  logic [DATA_W-1:0] in13,
   input  logic [DATA_W-1:0] in14,
   input  logic [DATA_W-1:0] in15,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   output logic [DATA_W-1:0] out8,
   output logic [DATA_W-1:0] out9,
   output logic [DATA_W-1:0] out10,
   output logic [DATA_W-1:0] out11,
   output logic [DATA_W-1:0] out12,
   output logic [DATA_W-1:0] out13,
   output logic [DATA_W-1:0] out14,
   output logic [DATA_W-1:0] out15,
   output logic              done,
   output logic              busy
);

   state_t           state_q, state_d;
   logic [1:0]       col_q;
   logic [15:0][7:0] in_bytes;
   logic [15:0][7:0] work_q, work_d;
   logic [15:0][7:0] out_q;
   logic [3:0][7:0]  col_in, col_out;
   logic             inv_q;
   logic             unused_in_hi;

   assign in_bytes = {in15[7:0], in14[7:0], in13[7:0], in12[7:0],
                      in11[7:0], in10[7:0], in9[7:0],  in8[7:0],
                      in7[7:0],  in6[7:0],  in5[7:0],  in4[7:0],
                      in3[7:0],  in2[7:0],  in1[7:0],  in0[7:0]};

   assign unused_in_hi = ^{in0[DATA_W-1:8],  in1[DATA_W-1:8],  in2[DATA_W-1:8],  in3[DATA_W-1:8],
                           in4[DATA_W-1:8],  in5[DATA_W-1:8],  in6[DATA_W-1:8],  in7[DATA_W-1:8],
                           in8[DATA_W-1:8],  in9[DATA_W-1:8],  in10[DATA_W-1:8], in11[DATA_W-1:8],
                           in12[DATA_W-1:8], in13[DATA_W-1:8], in14[DATA_W-1:8], in15[DATA_W-1:8]};

   mix_column_single u_mix (
`ifdef MIX_COLUMNS_INV_EN
      .inv     (inv_q),
`endif
      .col_in  (col_in),
      .col_out (col_out)
   );

   // Column c of the row-major state lives at byte index {row, c}.
   always_comb begin
      work_d = work_q;
      for (int unsigned r = 0; r < 4; r++) begin
         col_in[r] = work_q[{2'(r), col_q}];
         work_d[{2'(r), col_q}] = col_out[r];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run) state_d = BUSY;
         BUSY:    if (col_q == 2'd3) state_d = DONE;
         DONE:    state_d = run ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // The last column's result goes straight into the output register so the
   // full block becomes visible in the same cycle done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         out_q  <= '0;
         col_q  <= '0;
         inv_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (run) begin
                  work_q <= in_bytes;
                  col_q  <= '0;
`ifdef MIX_COLUMNS_INV_EN
                  inv_q  <= inv;
`else
                  inv_q  <= 1'b0;
`endif
               end
            end
            BUSY: begin
               work_q <= work_d;
               col_q  <= col_q + 2'd1;
               if (col_q == 2'd3) out_q <= work_d;
            end
            default: ;
         endcase
      end
   end

   assign done = (state_q == DONE);
   assign busy = (state_q != IDLE);

   assign out0  = DATA_W'(out_q[0]);
   assign out1  = DATA_W'(out_q[1]);
   assign out2  = DATA_W'(out_q[2]);
   assign out3  = DATA_W'(out_q[3]);
   assign out4  = DATA_W'(out_q[4]);
   assign out5  = DATA_W'(out_q[5]);
   assign out6  = DATA_W'(out_q[6]);
   assign out7  = DATA_W'(out_q[7]);
   assign out8  = DATA_W'(out_q[8]);
   assign out9  = DATA_W'(out_q[9]);
   assign out10 = DATA_W'(out_q[10]);
   assign out11 = DATA_W'(out_q[11]);
   assign out12 = DATA_W'(out_q[12]);
   assign out13 = DATA_W'(out_q[13]);
   assign out14 = DATA_W'(out_q[14]);
   assign out15 = DATA_W'(out_q[15]);

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Directed + randomized self-checking bench for mix_columns_pipe against a GF(2^8) matrix model.
module tb_mix_columns_pipe;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
   logic inv = 1'b0;
`endif
   logic [16*W-1:0] in_all = '0;
   logic [16*W-1:0] out_all;
   logic [W-1:0]    o [16];
   logic            done, busy;

   int errors = 0;
   int checks = 0;
   logic [16*W-1:0] last_out = '0;

   always #5 clk = ~clk;

   mix_columns_pipe #(.DATA_W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
`ifdef MIX_COLUMNS_INV_EN
      .inv  (inv),
`endif
      .in0  (in_all[0*W+:W]),  .in1  (in_all[1*W+:W]),  .in2  (in_all[2*W+:W]),  .in3  (in_all[3*W+:W]),
      .in4  (in_all[4*W+:W]),  .in5  (in_all[5*W+:W]),  .in6  (in_all[6*W+:W]),  .in7  (in_all[7*W+:W]),
      .in8  (in_all[8*W+:W]),  .in9  (in_all[9*W+:W]),  .in10 (in_all[10*W+:W]), .in11 (in_all[11*W+:W]),
      .in12 (in_all[12*W+:W]), .in13 (in_all[13*W+:W]), .in14 (in_all[14*W+:W]), .in15 (in_all[15*W+:W]),
      .out0 (o[0]),  .out1 (o[1]),  .out2 (o[2]),  .out3 (o[3]),
      .out4 (o[4]),  .out5 (o[5]),  .out6 (o[6]),  .out7 (o[7]),
      .out8 (o[8]),  .out9 (o[9]),  .out10(o[10]), .out11(o[11]),
      .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
      .done (done),
      .busy (busy)
   );

   always_comb begin
      out_all = '0;
      for (int i = 0; i < 16; i++) out_all[i*W+:W] = o[i];
   end

   // Plain carry-less multiply modulo x^8+x^4+x^3+x+1.
   function automatic int gmul(input int a, input int b);
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b & 1) != 0) p = p ^ a;
         a = a << 1;
         if ((a & 'h100) != 0) a = a ^ 'h11B;
         b = b >> 1;
      end
      return p & 'hFF;
   endfunction

   // out[r][c] = sum_j M[r][j] * s[j][c], M circulant with first row coef.
   function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inverse);
      int coef [4];
      logic [127:0] res = '0;
      if (inverse) coef = '{'h0E, 'h0B, 'h0D, 'h09};
      else         coef = '{'h02, 'h03, 'h01, 'h01};
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            int acc = 0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(int'(s[8*(4*j+c)+:8]), coef[(j - r + 4) % 4]);
            res[8*(4*r+c)+:8] = 8'(acc);
         end
      return res;
   endfunction

   function automatic logic [16*W-1:0] widen(input logic [127:0] s);
      logic [16*W-1:0] v = '0;
      for (int i = 0; i < 16; i++) v[i*W+:W] = W'(s[8*i+:8]);
      return v;
   endfunction

   function automatic logic [127:0] narrow(input logic [16*W-1:0] v);
      logic [127:0] s;
      for (int i = 0; i < 16; i++) s[8*i+:8] = v[i*W+:8];
      return s;
   endfunction

   // v = {row0, row1, row2, row3} of column c.
   function automatic logic [127:0] put_col(input logic [127:0] s, input int c, input logic [31:0] v);
      for (int r = 0; r < 4; r++) s[8*(4*r+c)+:8] = v[8*(3-r)+:8];
      return s;
   endfunction

   function automatic logic [127:0] rand_state();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive(input logic [127:0] s);
      for (int i = 0; i < 16; i++) begin
         logic [31:0] r = $urandom();
         in_all[i*W+:W] = {r[31:8], s[8*i+:8]};
      end
   endtask

   task automatic check(input string tag, input logic [16*W-1:0] obs, input logic [16*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle or in DONE; returns at the negedge after done dropped.
   task automatic run_op(input string tag, input logic [127:0] s, input bit inv_sel,
                         input bit hold, output logic [127:0] got);
      logic [16*W-1:0] exp = widen(mix_ref(s, inv_sel));
      drive(s);
      run = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
      inv = inv_sel;
`endif
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         run = hold;
         drive(rand_state());
`ifdef MIX_COLUMNS_INV_EN
         inv = hold ? ~inv_sel : inv_sel;
`endif
         check({tag, " busy/done"}, {busy, done}, 2'b10);
         check({tag, " out hold"}, out_all, last_out);
      end
      @(negedge clk);
      run = 1'b0;
      check({tag, " done"}, {busy, done}, 2'b11);
      check({tag, " result"}, out_all, exp);
      last_out = exp;
      got = narrow(out_all);
      @(negedge clk);
      check({tag, " idle"}, {busy, done}, 2'b00);
      check({tag, " stable"}, out_all, exp);
   endtask

   initial begin
      logic [127:0] s, got, hist [15];
      logic [31:0]  col0;

      // Reset state
      drive(rand_state());
      run = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      check("reset busy/done", {busy, done}, 2'b00);
      check("reset out", out_all, '0);

      // Known column db,13,53,45 -> 8e,4d,a1,bc
      s = put_col(rand_state(), 0, 32'hdb135345);
      run_op("vec026", s, 1'b0, 1'b0, got);
      col0 = {got[8*0+:8], got[8*4+:8], got[8*8+:8], got[8*12+:8]};
      check("vec026 col0", col0, 32'h8e4da1bc);

      // Four standard columns, upper bits of inputs junk, outputs zero-extended
      s = put_col('0, 0, 32'hf20a225c);
      s = put_col(s, 1, 32'h01010101);
      s = put_col(s, 2, 32'hc6c6c6c6);
      s = put_col(s, 3, 32'hd4d4d4d5);
      run_op("vec027", s, 1'b0, 1'b0, got);
      s = put_col('0, 0, 32'h9fdc589d);
      s = put_col(s, 1, 32'h01010101);
      s = put_col(s, 2, 32'hc6c6c6c6);
      s = put_col(s, 3, 32'hd5d5d7d6);
      check("vec027 const", out_all, widen(s));

      // Random states, some with run held high through BUSY
      for (int n = 0; n < 6; n++) run_op("rand", rand_state(), 1'b0, n[0], got);

      // run held continuously: accept on edges 0, 5, 10
      run = 1'b1;
      for (int k = 0; k < 15; k++) begin
         hist[k] = rand_state();
         drive(hist[k]);
         @(negedge clk);
         check("stream done", done, (k % 5) == 4);
         check("stream busy", busy, 1'b1);
         if ((k % 5) == 4) last_out = widen(mix_ref(hist[k-4], 1'b0));
         check("stream out", out_all, last_out);
      end
      run = 1'b0;
      @(negedge clk);
      check("stream idle", {busy, done}, 2'b00);

      // Reset at T+3 aborts the block
      drive(rand_state());
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_out = '0;
      check("abort busy/done", {busy, done}, 2'b00);
      check("abort out", out_all, '0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("abort no done", {busy, done}, 2'b00);
         check("abort out held", out_all, '0);
      end
      run_op("after abort", rand_state(), 1'b0, 1'b0, got);

`ifdef MIX_COLUMNS_INV_EN
      s = put_col(rand_state(), 0, 32'h8e4da1bc);
      run_op("inv vec", s, 1'b1, 1'b0, got);
      col0 = {got[8*0+:8], got[8*4+:8], got[8*8+:8], got[8*12+:8]};
      check("inv vec col0", col0, 32'hdb135345);
      for (int n = 0; n < 4; n++) begin
         logic [127:0] orig = rand_state();
         run_op("roundtrip fwd", orig, 1'b0, n[0], got);
         run_op("roundtrip inv", got, 1'b1, n[0], got);
         check("roundtrip", widen(got), widen(orig));
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
